// File: rtl/nibble_pkg.sv
// Shared types for the nibble datapath (deserializer and the popcount
// classifier fed by it).
//   NIB_W    : width of one nibble word
//   nibble_t : one assembled word
//   classify : reference popcount rule of the downstream classifier,
//              1 when exactly two or three bits of the word are set
package nibble_pkg;

  localparam int NIB_W = 4;

  typedef logic [NIB_W-1:0] nibble_t;

  function automatic logic classify(input nibble_t n);
    logic [2:0] c;
    c = 3'd0;
    for (int k = 0; k < NIB_W; k++) begin
      c = c + {2'b00, n[k]};
    end
    return (c == 3'd2) || (c == 3'd3);
  endfunction

endpackage

// File: rtl/nibble_deserializer.sv
// Serial-to-parallel word assembler with a valid/ready output stage.
// Bits arrive LSB first and are packed into W-bit words. Each finished word
// is held on a registered output until downstream takes it. While the output
// is occupied, one complete word can wait in the shift register. After that,
// the serial side is back-pressured.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   ser_in     serial data bit
//   ser_valid  ser_in is valid this cycle
//   ser_ready  block accepts a serial bit this cycle (depends on state only)
//   flush      drop any partial or stalled word and realign to bit 0
//   nib_out    assembled word, bit k = k-th accepted bit
//   nib_valid  nib_out holds an undelivered word
//   nib_ready  downstream takes nib_out this cycle
//   nib_count  words delivered, modulo 2^CW
module nibble_deserializer
  import nibble_pkg::*;
#(
  parameter int W  = NIB_W,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ser_in,
  input  logic          ser_valid,
  output logic          ser_ready,
  input  logic          flush,
  output logic [W-1:0]  nib_out,
  output logic          nib_valid,
  input  logic          nib_ready,
  output logic [CW-1:0] nib_count
);

  localparam int CNTW = $clog2(W + 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(W);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(W - 1);

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    sh_q, sh_d;
  logic [W-1:0]    nib_out_q, nib_out_d;
  logic            nib_valid_q, nib_valid_d;
  logic [CW-1:0]   nib_count_q, nib_count_d;

  logic            accept_s;
  logic            pop_s;
  logic            out_free_s;
  logic            load_s;
  logic [W-1:0]    load_word_s;
  logic [W-1:0]    asm_s;

  // cnt == W means a complete word is parked in sh waiting for the output.
  assign ser_ready  = (cnt_q != CNT_FULL);
  assign accept_s   = ser_valid & ser_ready;
  assign pop_s      = nib_valid_q & nib_ready;
  assign out_free_s = ~nib_valid_q | nib_ready;

  // Next-state logic for the assembler, output stage and delivery counter.
  always_comb begin
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    nib_out_d   = nib_out_q;
    nib_valid_d = nib_valid_q;
    nib_count_d = nib_count_q;
    load_s      = 1'b0;
    load_word_s = sh_q;

    asm_s        = sh_q;
    asm_s[W-1]   = ser_in;

    if (pop_s) begin
      nib_count_d = nib_count_q + {{(CW-1){1'b0}}, 1'b1};
      nib_valid_d = 1'b0;
    end else begin
      nib_count_d = nib_count_q;
    end

    if (flush) begin
      // Flush wins over accept and also drops a parked word.
      cnt_d = '0;
      sh_d  = '0;
    end else if (cnt_q == CNT_FULL) begin
      if (out_free_s) begin
        load_s      = 1'b1;
        load_word_s = sh_q;
        cnt_d       = '0;
        sh_d        = '0;
      end else begin
        cnt_d = cnt_q;
      end
    end else if (accept_s) begin
      if (cnt_q == CNT_LAST) begin
        if (out_free_s) begin
          load_s      = 1'b1;
          load_word_s = asm_s;
          cnt_d       = '0;
          sh_d        = '0;
        end else begin
          sh_d  = asm_s;
          cnt_d = CNT_FULL;
        end
      end else begin
        // Decode the bit position explicitly so the index never exceeds W-1.
        for (int k = 0; k < W; k++) begin
          if (cnt_q == CNTW'(k)) begin
            sh_d[k] = ser_in;
          end else begin
            sh_d[k] = sh_q[k];
          end
        end
        cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end

    // A load in the same cycle as a pop keeps valid high: no bubble.
    if (load_s) begin
      nib_out_d   = load_word_s;
      nib_valid_d = 1'b1;
    end else begin
      nib_out_d = nib_out_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      sh_q        <= '0;
      nib_out_q   <= '0;
      nib_valid_q <= 1'b0;
      nib_count_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      nib_out_q   <= nib_out_d;
      nib_valid_q <= nib_valid_d;
      nib_count_q <= nib_count_d;
    end
  end

  assign nib_out   = nib_out_q;
  assign nib_valid = nib_valid_q;
  assign nib_count = nib_count_q;

endmodule

// File: tb/tb_nibble_deserializer.sv
module tb_nibble_deserializer;
  import nibble_pkg::*;

  logic       clk;
  logic       rst;
  logic       ser_in;
  logic       ser_valid;
  logic       ser_ready;
  logic       flush;
  logic [3:0] nib_out;
  logic       nib_valid;
  logic       nib_ready;
  logic [7:0] nib_count;

  int n_checks;
  int n_fail;

  nibble_deserializer #(.W(4), .CW(8)) dut (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid),
    .ser_ready(ser_ready), .flush(flush), .nib_out(nib_out),
    .nib_valid(nib_valid), .nib_ready(nib_ready), .nib_count(nib_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r, v, d, f, nr;
    logic       esr, env;
    logic [3:0] eno;
    logic [7:0] enc;
    logic       cko, eo;
  } vec_t;

  vec_t tbl[$];

  // Bench-side reference model for the streaming sequences.
  logic       m_valid;
  logic [3:0] m_out;
  logic [7:0] m_count;

  task automatic add(input logic r, v, d, f, nr, esr, env,
                     input logic [3:0] eno, input logic [7:0] enc,
                     input logic cko = 1'b0, input logic eo = 1'b0);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.f = f; t.nr = nr;
    t.esr = esr; t.env = env; t.eno = eno; t.enc = enc;
    t.cko = cko; t.eo = eo;
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, got, want);
    end
  endtask

  // Drive one cycle of inputs, clock, then compare outputs 1ns after the edge.
  task automatic step(input string nm, input int idx, input logic r, v, d, f, nr,
                      input logic esr, env, input logic [3:0] eno, input logic [7:0] enc);
    rst = r; ser_valid = v; ser_in = d; flush = f; nib_ready = nr;
    @(posedge clk);
    #1;
    chk({nm, ".ser_ready"}, idx, 32'(ser_ready), 32'(esr));
    chk({nm, ".nib_valid"}, idx, 32'(nib_valid), 32'(env));
    chk({nm, ".nib_out"},   idx, 32'(nib_out),   32'(eno));
    chk({nm, ".nib_count"}, idx, 32'(nib_count), 32'(enc));
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_out = 4'h0; m_count = 8'h00;
  endtask

  // Stream one word LSB first with nib_ready held high.
  task automatic send_word_cont(input string nm, input logic [3:0] w);
    for (int b = 0; b < 4; b++) begin
      if (m_valid) begin
        m_count = m_count + 8'd1;
        m_valid = 1'b0;
      end
      if (b == 3) begin
        m_valid = 1'b1;
        m_out   = w;
      end
      step(nm, b, 1'b0, 1'b1, w[b], 1'b0, 1'b1, 1'b1, m_valid, m_out, m_count);
    end
  endtask

  task automatic idle_ready(input string nm);
    if (m_valid) begin
      m_count = m_count + 8'd1;
      m_valid = 1'b0;
    end
    step(nm, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, m_valid, m_out, m_count);
  endtask

  logic [15:0] pat;
  logic [3:0]  w;

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; ser_in = 1'b0; ser_valid = 1'b0; flush = 1'b0; nib_ready = 1'b0;

    // r v d f nr | sr nv no nc
    // Basic assembly 1,0,1,1 -> 1101, then popped.
    add(1,0,0,0,0, 1,0,4'h0,8'd0);
    add(0,1,1,0,1, 1,0,4'h0,8'd0);
    add(0,1,0,0,1, 1,0,4'h0,8'd0);
    add(0,1,1,0,1, 1,0,4'h0,8'd0);
    add(0,1,1,0,1, 1,1,4'hD,8'd0, 1'b1, 1'b1);
    add(0,0,0,0,1, 1,0,4'hD,8'd1);
    // Backpressure: 0011 held, 1111 parked, ser_ready drops.
    add(1,0,0,0,0, 1,0,4'h0,8'd0);
    add(0,1,1,0,0, 1,0,4'h0,8'd0);
    add(0,1,1,0,0, 1,0,4'h0,8'd0);
    add(0,1,0,0,0, 1,0,4'h0,8'd0);
    add(0,1,0,0,0, 1,1,4'h3,8'd0);
    add(0,1,1,0,0, 1,1,4'h3,8'd0);
    add(0,1,1,0,0, 1,1,4'h3,8'd0);
    add(0,1,1,0,0, 1,1,4'h3,8'd0);
    add(0,1,1,0,0, 0,1,4'h3,8'd0);
    add(0,1,0,0,0, 0,1,4'h3,8'd0);
    add(0,1,0,0,1, 1,1,4'hF,8'd1);
    add(0,0,0,0,1, 1,0,4'hF,8'd2);
    // Flush drops the partial 1,1 and the bit offered with it.
    add(1,0,0,0,0, 1,0,4'h0,8'd0);
    add(0,1,1,0,1, 1,0,4'h0,8'd0);
    add(0,1,1,0,1, 1,0,4'h0,8'd0);
    add(0,1,1,1,1, 1,0,4'h0,8'd0);
    add(0,1,0,0,1, 1,0,4'h0,8'd0);
    add(0,1,1,0,1, 1,0,4'h0,8'd0);
    add(0,1,1,0,1, 1,0,4'h0,8'd0);
    add(0,1,0,0,1, 1,1,4'h6,8'd0, 1'b1, 1'b1);
    add(0,0,0,0,1, 1,0,4'h6,8'd1);
    // Flush discards a parked complete word.
    add(0,1,1,0,0, 1,0,4'h6,8'd1);
    add(0,1,0,0,0, 1,0,4'h6,8'd1);
    add(0,1,0,0,0, 1,0,4'h6,8'd1);
    add(0,1,0,0,0, 1,1,4'h1,8'd1, 1'b1, 1'b0);
    add(0,1,1,0,0, 1,1,4'h1,8'd1);
    add(0,1,1,0,0, 1,1,4'h1,8'd1);
    add(0,1,1,0,0, 1,1,4'h1,8'd1);
    add(0,1,1,0,0, 0,1,4'h1,8'd1);
    add(0,1,1,1,0, 1,1,4'h1,8'd1);
    add(0,0,0,0,1, 1,0,4'h1,8'd2);
    add(0,0,0,0,1, 1,0,4'h1,8'd2);
    // Reset mid-word with ser_valid high, then 1,0,0,0 -> 0001.
    add(0,1,1,0,1, 1,0,4'h1,8'd2);
    add(0,1,1,0,1, 1,0,4'h1,8'd2);
    add(0,1,1,0,1, 1,0,4'h1,8'd2);
    add(1,1,1,0,1, 1,0,4'h0,8'd0);
    add(0,1,1,0,1, 1,0,4'h0,8'd0);
    add(0,1,0,0,1, 1,0,4'h0,8'd0);
    add(0,1,0,0,1, 1,0,4'h0,8'd0);
    add(0,1,0,0,1, 1,1,4'h1,8'd0);
    add(0,0,0,0,1, 1,0,4'h1,8'd1);

    for (int i = 0; i < tbl.size(); i++) begin
      step("vec", i, tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].nr,
           tbl[i].esr, tbl[i].env, tbl[i].eno, tbl[i].enc);
      if (tbl[i].cko) begin
        chk("classify", i, 32'(classify(nib_out)), 32'(tbl[i].eo));
      end
    end

    // Continuous stream 0x5A3C: words C,3,A,5 with no bubble.
    step("rst3", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 8'd0);
    model_reset();
    pat = 16'h5A3C;
    for (int k = 0; k < 4; k++) begin
      w = pat[4*k +: 4];
      send_word_cont("stream", w);
    end
    idle_ready("stream_end");
    chk("stream_count", 0, 32'(nib_count), 32'd4);

    // Counter wrap: 256 pops return to 0, the 257th gives 1.
    step("rst6", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 8'd0);
    model_reset();
    for (int k = 0; k < 256; k++) begin
      w = 4'(k);
      send_word_cont("wrap", w);
    end
    idle_ready("wrap_end");
    chk("wrap_zero", 0, 32'(nib_count), 32'd0);
    send_word_cont("wrap", 4'h9);
    idle_ready("wrap_end2");
    chk("wrap_one", 0, 32'(nib_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
